// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU commands, shift types,
// status-flag bit positions, forwarding selects and the EX/MEM record.
package exe_pkg;

  localparam int unsigned DataW = 32;

  // ALU command encodings. Codes not listed here are treated as no-ops.
  typedef enum logic [3:0] {
    AluNop = 4'b0000,
    AluMov = 4'b0001,
    AluAdd = 4'b0010,
    AluAdc = 4'b0011,
    AluSub = 4'b0100,
    AluSbc = 4'b0101,
    AluAnd = 4'b0110,
    AluOrr = 4'b0111,
    AluEor = 4'b1000,
    AluMvn = 4'b1001
  } alu_cmd_e;

  // Register-operand shift types, from shifter operand bits [6:5].
  typedef enum logic [1:0] {
    ShLsl = 2'b00,
    ShLsr = 2'b01,
    ShAsr = 2'b10,
    ShRor = 2'b11
  } shift_e;

  // Bit positions inside the {N,Z,C,V} status nibble.
  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  // Operand source selects used when forwarding is built in.
  typedef enum logic [1:0] {
    FwdIdEx  = 2'b00,
    FwdMem   = 2'b01,
    FwdWb    = 2'b10,
    FwdIdEx2 = 2'b11
  } fwd_sel_e;

  // EX/MEM pipeline record.
  typedef struct packed {
    logic [DataW-1:0] alu_res;
    logic [DataW-1:0] val_rm;
    logic [3:0]       dest;
    logic             mem_read;
    logic             mem_write;
    logic             wb_en;
  } exmem_t;

  // Rotate right; the left-shift amount (0 - amt) wraps to 0 when amt is 0.
  function automatic logic [DataW-1:0] ror32(input logic [DataW-1:0] v, input logic [4:0] amt);
    return (v >> amt) | (v << (5'd0 - amt));
  endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU with NZCV generation. Add and subtract share one 33-bit
// adder; subtraction feeds the inverted Val2 so bit 32 is directly NOT borrow.
module exe_alu
  import exe_pkg::*;
(
  input  logic [DataW-1:0] rn_i,
  input  logic [DataW-1:0] val2_i,
  input  logic [3:0]       cmd_i,
  input  logic [3:0]       status_i,
  output logic [DataW-1:0] res_o,
  output logic [3:0]       status_o
);

  logic [DataW-1:0] add_b;
  logic             add_cin;
  logic [DataW:0]   sum;
  logic             overflow;

  // Shared adder: ADD/ADC use Val2, SUB/SBC use ~Val2 with the carry as NOT borrow.
  always_comb begin
    add_b   = val2_i;
    add_cin = 1'b0;
    unique case (alu_cmd_e'(cmd_i))
      AluAdc:  add_cin = status_i[FlagC];
      AluSub:  begin
        add_b   = ~val2_i;
        add_cin = 1'b1;
      end
      AluSbc:  begin
        add_b   = ~val2_i;
        add_cin = status_i[FlagC];
      end
      default: ;
    endcase
    sum      = {1'b0, rn_i} + {1'b0, add_b} + {{DataW{1'b0}}, add_cin};
    overflow = (rn_i[DataW-1] == add_b[DataW-1]) && (sum[DataW-1] != rn_i[DataW-1]);
  end

  // Result select and flag update; unknown commands give 0 and keep all flags.
  always_comb begin
    res_o    = '0;
    status_o = status_i;
    case (alu_cmd_e'(cmd_i))
      AluMov: res_o = val2_i;
      AluMvn: res_o = ~val2_i;
      AluAdd, AluAdc, AluSub, AluSbc: begin
        res_o           = sum[DataW-1:0];
        status_o[FlagC] = sum[DataW];
        status_o[FlagV] = overflow;
      end
      AluAnd: res_o = rn_i & val2_i;
      AluOrr: res_o = rn_i | val2_i;
      AluEor: res_o = rn_i ^ val2_i;
      default: ;
    endcase
    case (alu_cmd_e'(cmd_i))
      AluMov, AluMvn, AluAdd, AluAdc, AluSub, AluSbc, AluAnd, AluOrr, AluEor: begin
        status_o[FlagN] = res_o[DataW-1];
        status_o[FlagZ] = (res_o == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU, NZCV status register, branch target
// and the EX/MEM pipeline register.
// Optional operand forwarding is built when EXE_FORWARDING_EN is defined.
// WIDTH is fixed at 32.
module exe_stage
  import exe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pcIn,
  input  logic [3:0]       aluCmdIn,
  input  logic             memReadIn,
  input  logic             memWriteIn,
  input  logic             wbEnIn,
  input  logic             branchIn,
  input  logic             sIn,
  input  logic [WIDTH-1:0] regRnIn,
  input  logic [WIDTH-1:0] regRmIn,
  input  logic             immIn,
  input  logic [11:0]      shiftOperandIn,
  input  logic [23:0]      imm24In,
  input  logic [3:0]       destIn,
  input  logic             freeze,
  input  logic             flush,
`ifdef EXE_FORWARDING_EN
  input  logic [1:0]       selSrc1,
  input  logic [1:0]       selSrc2,
  input  logic [WIDTH-1:0] memFwdVal,
  input  logic [WIDTH-1:0] wbFwdVal,
`endif
  output logic             branchTaken,
  output logic [WIDTH-1:0] branchAddr,
  output logic [3:0]       statusOut,
  output logic [WIDTH-1:0] aluResOut,
  output logic [WIDTH-1:0] valRmOut,
  output logic [3:0]       destOut,
  output logic             memReadOut,
  output logic             memWriteOut,
  output logic             wbEnOut
);

  logic [DataW-1:0] rn_eff;
  logic [DataW-1:0] rm_eff;
  logic [DataW-1:0] val2;
  logic [4:0]       shamt;
  logic [DataW-1:0] alu_res;
  logic [3:0]       alu_status;
  logic [3:0]       status_d, status_q;
  exmem_t           exmem_d, exmem_q;

`ifdef EXE_FORWARDING_EN
  // Operand select: forwarded values override the ID/EX operands.
  always_comb begin
    case (fwd_sel_e'(selSrc1))
      FwdMem:  rn_eff = memFwdVal;
      FwdWb:   rn_eff = wbFwdVal;
      default: rn_eff = regRnIn;
    endcase
    case (fwd_sel_e'(selSrc2))
      FwdMem:  rm_eff = memFwdVal;
      FwdWb:   rm_eff = wbFwdVal;
      default: rm_eff = regRmIn;
    endcase
  end
`else
  assign rn_eff = regRnIn;
  assign rm_eff = regRmIn;
`endif

  assign shamt = shiftOperandIn[11:7];

  // Val2: rotated immediate, else raw 12-bit memory offset, else shifted Rm.
  // A zero shift amount leaves Rm untouched for every shift type.
  always_comb begin
    val2 = rm_eff;
    if (immIn) begin
      val2 = ror32({24'b0, shiftOperandIn[7:0]}, {shiftOperandIn[11:8], 1'b0});
    end else if (memReadIn || memWriteIn) begin
      val2 = {20'b0, shiftOperandIn};
    end else begin
      unique case (shift_e'(shiftOperandIn[6:5]))
        ShLsl: val2 = rm_eff << shamt;
        ShLsr: val2 = rm_eff >> shamt;
        ShAsr: val2 = $unsigned($signed(rm_eff) >>> shamt);
        ShRor: val2 = ror32(rm_eff, shamt);
      endcase
    end
  end

  exe_alu u_alu (
    .rn_i     (rn_eff),
    .val2_i   (val2),
    .cmd_i    (aluCmdIn),
    .status_i (status_q),
    .res_o    (alu_res),
    .status_o (alu_status)
  );

  // Branch target: PC+4 plus the sign-extended word offset.
  assign branchTaken = branchIn;
  assign branchAddr  = pcIn + {{6{imm24In[23]}}, imm24In, 2'b00};

  // Status loads only for S-instructions that are neither stalled nor squashed.
  always_comb begin
    status_d = status_q;
    if (sIn && !freeze && !flush) begin
      status_d = alu_status;
    end
  end

  // Status register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  // EX/MEM next state: flush bubbles the control bits but still loads data,
  // freeze holds everything.
  always_comb begin
    exmem_d = exmem_q;
    if (flush || !freeze) begin
      exmem_d.alu_res   = alu_res;
      exmem_d.val_rm    = rm_eff;
      exmem_d.dest      = destIn;
      exmem_d.mem_read  = memReadIn && !flush;
      exmem_d.mem_write = memWriteIn && !flush;
      exmem_d.wb_en     = wbEnIn && !flush;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign statusOut   = status_q;
  assign aluResOut   = exmem_q.alu_res;
  assign valRmOut    = exmem_q.val_rm;
  assign destOut     = exmem_q.dest;
  assign memReadOut  = exmem_q.mem_read;
  assign memWriteOut = exmem_q.mem_write;
  assign wbEnOut     = exmem_q.wb_en;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed vector table, hand-written
// freeze/flush/branch/reset sequences, and randomized traffic against a
// behavioural model built from plain integer arithmetic.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcIn, regRnIn, regRmIn;
  logic [3:0]  aluCmdIn, destIn;
  logic        memReadIn, memWriteIn, wbEnIn, branchIn, sIn, immIn;
  logic [11:0] shiftOperandIn;
  logic [23:0] imm24In;
  logic        freeze, flush;
  logic        branchTaken;
  logic [31:0] branchAddr, aluResOut, valRmOut;
  logic [3:0]  statusOut, destOut;
  logic        memReadOut, memWriteOut, wbEnOut;

  always #5 clk = ~clk;

  exe_stage #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pcIn           (pcIn),
    .aluCmdIn       (aluCmdIn),
    .memReadIn      (memReadIn),
    .memWriteIn     (memWriteIn),
    .wbEnIn         (wbEnIn),
    .branchIn       (branchIn),
    .sIn            (sIn),
    .regRnIn        (regRnIn),
    .regRmIn        (regRmIn),
    .immIn          (immIn),
    .shiftOperandIn (shiftOperandIn),
    .imm24In        (imm24In),
    .destIn         (destIn),
    .freeze         (freeze),
    .flush          (flush),
`ifdef EXE_FORWARDING_EN
    .selSrc1        (2'b00),
    .selSrc2        (2'b00),
    .memFwdVal      (32'h0),
    .wbFwdVal       (32'h0),
`endif
    .branchTaken    (branchTaken),
    .branchAddr     (branchAddr),
    .statusOut      (statusOut),
    .aluResOut      (aluResOut),
    .valRmOut       (valRmOut),
    .destOut        (destOut),
    .memReadOut     (memReadOut),
    .memWriteOut    (memWriteOut),
    .wbEnOut        (wbEnOut)
  );

  typedef struct {
    logic [31:0] rn, rm, pc;
    logic [23:0] imm24;
    logic        imm;
    logic [11:0] so;
    logic [3:0]  cmd, dest;
    logic        s, mr, mw, wb, br, frz, fl;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] res;
    logic [3:0]  st;
    logic        wb, mw;
  } vec_t;

  localparam longint TWO32 = 64'sh1_0000_0000;
  localparam longint MAXS  = 64'sh7FFF_FFFF;
  localparam longint MINS  = -64'sh8000_0000;

  int total = 0;
  int bad   = 0;

  // Model state.
  logic [31:0] m_res, m_valrm;
  logic [3:0]  m_status, m_dest;
  logic        m_mr, m_mw, m_wb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic [31:0] rn, input logic [31:0] rm, input logic imm,
                             input logic [11:0] so, input logic [3:0] cmd, input logic s,
                             input logic mr, input logic mw, input logic wb);
    in_t v;
    v.rn = rn; v.rm = rm; v.imm = imm; v.so = so; v.cmd = cmd; v.s = s;
    v.mr = mr; v.mw = mw; v.wb = wb; v.br = 1'b0; v.pc = 32'h100; v.imm24 = 24'h0;
    v.dest = 4'h5; v.frz = 1'b0; v.fl = 1'b0;
    return v;
  endfunction

  function automatic in_t rnd_in();
    in_t v;
    logic [31:0] r;
    v.rn = $urandom;
    v.rm = ($urandom_range(3) == 0) ? 32'h8000_0000 | $urandom_range(255) : $urandom;
    r = $urandom;
    v.so = r[11:0]; v.cmd = r[15:12]; v.dest = r[19:16]; v.s = r[20]; v.wb = r[21];
    v.br = r[22];
    v.imm = ($urandom_range(3) == 0);
    v.mr = ($urandom_range(5) == 0);
    v.mw = ($urandom_range(5) == 0);
    v.pc = $urandom;
    r = $urandom;
    v.imm24 = r[23:0];
    v.frz = ($urandom_range(7) == 0);
    v.fl = ($urandom_range(7) == 0);
    return v;
  endfunction

  task automatic drive(input in_t v);
    regRnIn = v.rn; regRmIn = v.rm; immIn = v.imm; shiftOperandIn = v.so;
    aluCmdIn = v.cmd; sIn = v.s; memReadIn = v.mr; memWriteIn = v.mw; wbEnIn = v.wb;
    branchIn = v.br; pcIn = v.pc; imm24In = v.imm24; destIn = v.dest;
    freeze = v.frz; flush = v.fl;
  endtask

  // Rotate right by n using division and remainder.
  function automatic logic [31:0] m_ror(input logic [31:0] val, input int n);
    longint x, p, r;
    if (n == 0) return val;
    x = longint'({32'b0, val});
    p = 64'sd1 << n;
    r = (x / p) + (x % p) * (64'sd1 << (32 - n));
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_val2(input in_t v);
    longint rm, p, sv, r;
    int amt;
    if (v.imm) return m_ror({24'b0, v.so[7:0]}, 2 * int'(v.so[11:8]));
    if (v.mr || v.mw) return {20'b0, v.so};
    amt = int'(v.so[11:7]);
    rm  = longint'({32'b0, v.rm});
    p   = 64'sd1 << amt;
    case (v.so[6:5])
      2'd0: r = (rm * p) % TWO32;
      2'd1: r = rm / p;
      2'd2: begin
        sv = longint'($signed(v.rm));
        r  = (sv >= 0) ? sv / p : -(((-sv) - 1) / p) - 1;
      end
      default: return m_ror(v.rm, amt);
    endcase
    return r[31:0];
  endfunction

  task automatic m_alu(input in_t v, input logic [31:0] v2, input logic [3:0] st,
                       output logic [31:0] res, output logic [3:0] nst);
    longint a, b, sa, sb, cy, bw, u, s;
    logic   valid;
    a  = longint'({32'b0, v.rn});
    b  = longint'({32'b0, v2});
    sa = longint'($signed(v.rn));
    sb = longint'($signed(v2));
    cy = st[1] ? 64'sd1 : 64'sd0;
    nst = st; valid = 1'b1; res = '0;
    case (v.cmd)
      4'h1: res = v2;
      4'h9: res = ~v2;
      4'h2, 4'h3: begin
        bw = (v.cmd == 4'h3) ? cy : 64'sd0;
        u = a + b + bw; s = sa + sb + bw;
        res = u[31:0]; nst[1] = (u >= TWO32); nst[0] = (s > MAXS) || (s < MINS);
      end
      4'h4, 4'h5: begin
        bw = (v.cmd == 4'h5) ? 64'sd1 - cy : 64'sd0;
        u = a - b - bw; s = sa - sb - bw;
        res = u[31:0]; nst[1] = (u >= 0); nst[0] = (s > MAXS) || (s < MINS);
      end
      4'h6: res = v.rn & v2;
      4'h7: res = v.rn | v2;
      4'h8: res = v.rn ^ v2;
      default: valid = 1'b0;
    endcase
    if (valid) begin
      nst[3] = res[31];
      nst[2] = (res == 32'h0);
    end
  endtask

  task automatic m_reset();
    m_res = '0; m_valrm = '0; m_status = '0; m_dest = '0; m_mr = 0; m_mw = 0; m_wb = 0;
  endtask

  // Drive one instruction, check the branch path, clock it, update the model.
  task automatic step(input in_t v);
    logic [31:0] res;
    logic [3:0]  nst;
    longint      off, t;
    drive(v);
    #1;
    off = v.imm24[23] ? longint'({40'b0, v.imm24}) - (64'sd1 << 24)
                      : longint'({40'b0, v.imm24});
    t = longint'({32'b0, v.pc}) + off * 4;
    check("branchAddr", {32'b0, branchAddr}, {32'b0, t[31:0]});
    check("branchTaken", {63'b0, branchTaken}, {63'b0, v.br});
    m_alu(v, m_val2(v), m_status, res, nst);
    @(posedge clk);
    if (v.s && !v.frz && !v.fl) m_status = nst;
    if (v.fl || !v.frz) begin
      m_res = res; m_valrm = v.rm; m_dest = v.dest;
      m_mr = v.mr && !v.fl; m_mw = v.mw && !v.fl; m_wb = v.wb && !v.fl;
    end
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_res"}, {32'b0, aluResOut}, {32'b0, m_res});
    check({tag, "_status"}, {60'b0, statusOut}, {60'b0, m_status});
    check({tag, "_ctrl"}, {25'b0, valRmOut, destOut, memReadOut, memWriteOut, wbEnOut},
          {25'b0, m_valrm, m_dest, m_mr, m_mw, m_wb});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_res"}, {32'b0, aluResOut}, 64'h0);
    check({tag, "_status"}, {60'b0, statusOut}, 64'h0);
    check({tag, "_ctrl"}, {25'b0, valRmOut, destOut, memReadOut, memWriteOut, wbEnOut}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[18];
    in_t         v;
    logic [31:0] h_res, h_valrm;
    logic [3:0]  h_st, h_dest;
    logic        h_wb;

    // Asynchronous reset with busy inputs; no clock edge has happened yet.
    rst = 1'b0;
    v = mk(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 12'hFFF, 4'h2, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(v);
    m_reset();
    #2;
    check_zero("reset_async");
    @(negedge clk);
    check_zero("reset_held");
    rst = 1'b1;

    vecs[0]  = '{mk(32'h7FFF_FFFF, 0, 1, 12'h001, 4'h2, 1, 0, 0, 1), 32'h8000_0000, 4'b1001, 1, 0};
    vecs[1]  = '{mk(0, 0, 1, 12'h4FF, 4'h1, 0, 0, 0, 1), 32'hFF00_0000, 4'b1001, 1, 0};
    vecs[2]  = '{mk(0, 32'h8000_0000, 0, 12'h0C0, 4'h1, 0, 0, 0, 1), 32'hC000_0000, 4'b1001, 1, 0};
    vecs[3]  = '{mk(0, 32'h8000_0000, 0, 12'h0A0, 4'h1, 0, 0, 0, 1), 32'h4000_0000, 4'b1001, 1, 0};
    vecs[4]  = '{mk(5, 5, 0, 12'h000, 4'h4, 1, 0, 0, 0), 32'h0, 4'b0110, 0, 0};
    vecs[5]  = '{mk(1, 1, 0, 12'h000, 4'h3, 1, 0, 0, 1), 32'h3, 4'b0000, 1, 0};
    vecs[6]  = '{mk(10, 3, 0, 12'h000, 4'h5, 1, 0, 0, 1), 32'h6, 4'b0010, 1, 0};
    vecs[7]  = '{mk(0, 0, 1, 12'h000, 4'h9, 1, 0, 0, 1), 32'hFFFF_FFFF, 4'b1010, 1, 0};
    vecs[8]  = '{mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 12'h000, 4'h6, 1, 0, 0, 1),
                 32'h00F0_00F0, 4'b0010, 1, 0};
    vecs[9]  = '{mk(0, 0, 0, 12'h000, 4'h7, 1, 0, 0, 1), 32'h0, 4'b0110, 1, 0};
    vecs[10] = '{mk(32'hA5A5_A5A5, 32'hFFFF_FFFF, 0, 12'h000, 4'h8, 1, 0, 0, 1),
                 32'h5A5A_5A5A, 4'b0010, 1, 0};
    vecs[11] = '{mk(32'h1234, 32'h5678, 0, 12'h000, 4'h0, 1, 0, 0, 1), 32'h0, 4'b0010, 1, 0};
    vecs[12] = '{mk(32'h1000, 32'h99, 0, 12'h123, 4'h2, 0, 1, 0, 1), 32'h1123, 4'b0010, 1, 0};
    vecs[13] = '{mk(0, 1, 0, 12'h260, 4'h1, 0, 0, 0, 1), 32'h1000_0000, 4'b0010, 1, 0};
    vecs[14] = '{mk(0, 3, 0, 12'hF80, 4'h1, 0, 0, 0, 1), 32'h8000_0000, 4'b0010, 1, 0};
    vecs[15] = '{mk(0, 0, 1, 12'h001, 4'h4, 1, 0, 0, 1), 32'hFFFF_FFFF, 4'b1000, 1, 0};
    vecs[16] = '{mk(32'h8000_0000, 0, 1, 12'h001, 4'h4, 1, 0, 1, 0), 32'h7FFF_FFFF, 4'b0011, 0, 1};
    vecs[17] = '{mk(32'hFFFF_FFFF, 0, 1, 12'h001, 4'h2, 1, 0, 0, 1), 32'h0, 4'b0110, 1, 0};

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].in);
      check($sformatf("vec%0d_res", i), {32'b0, aluResOut}, {32'b0, vecs[i].res});
      check($sformatf("vec%0d_status", i), {60'b0, statusOut}, {60'b0, vecs[i].st});
      check($sformatf("vec%0d_wb", i), {63'b0, wbEnOut}, {63'b0, vecs[i].wb});
      check($sformatf("vec%0d_mw", i), {63'b0, memWriteOut}, {63'b0, vecs[i].mw});
    end

    // Freeze: three edges with fresh inputs must leave every output alone.
    h_res = m_res; h_valrm = m_valrm; h_st = m_status; h_dest = m_dest; h_wb = m_wb;
    for (int k = 0; k < 3; k++) begin
      v = mk(32'h100 + k, 32'h777, 0, 12'h000, 4'h2, 1, 0, 1, 1);
      v.dest = 4'hA; v.frz = 1'b1;
      step(v);
      check("freeze_res", {32'b0, aluResOut}, {32'b0, h_res});
      check("freeze_status", {60'b0, statusOut}, {60'b0, h_st});
      check("freeze_ctrl", {27'b0, valRmOut, destOut, wbEnOut}, {27'b0, h_valrm, h_dest, h_wb});
    end

    // Flush: bubble the control bits, data still loads, status untouched.
    v = mk(1, 32'h55, 1, 12'h001, 4'h2, 1, 0, 1, 1);
    v.fl = 1'b1;
    step(v);
    check("flush_mw", {63'b0, memWriteOut}, 64'h0);
    check("flush_wb", {63'b0, wbEnOut}, 64'h0);
    check("flush_res", {32'b0, aluResOut}, 64'h2);
    check("flush_status", {60'b0, statusOut}, {60'b0, h_st});

    // Backward branch resolved combinationally.
    v = mk(0, 0, 0, 12'h000, 4'h0, 0, 0, 0, 0);
    v.pc = 32'h100; v.imm24 = 24'hFFFFFE; v.br = 1'b1;
    drive(v);
    #1;
    check("branch_back", {32'b0, branchAddr}, 64'hF8);
    check("branch_taken", {63'b0, branchTaken}, 64'h1);
    step(v);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(rnd_in());
      check_model("rnd");
    end

    // Reset mid-stream: state drops immediately, first edge after release loads.
    step(mk(0, 0, 1, 12'h000, 4'h9, 1, 0, 1, 1));
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    check_zero("reset_mid");
    @(negedge clk);
    rst = 1'b1;
    step(mk(3, 4, 0, 12'h000, 4'h2, 1, 0, 0, 1));
    check("post_reset_res", {32'b0, aluResOut}, 64'h7);
    check("post_reset_status", {60'b0, statusOut}, 64'h0);
    check("post_reset_wb", {63'b0, wbEnOut}, 64'h1);
    check_model("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM-subset pipeline. It consumes the ID/EX register outputs.
- Generates Val2 from the shifter operand, runs the ALU, and holds the NZCV status register.
- Resolves branch target and taken signals combinationally.
- Registers results into an integrated EX/MEM pipeline register that feeds the memory stage.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- pcIn  in  32  PC+4 of the instruction in EX
- aluCmdIn  in  4  ALU command
- memReadIn, memWriteIn, wbEnIn, branchIn, sIn  in  1 each  control bits from ID/EX
- regRnIn, regRmIn  in  32  operand values
- immIn  in  1  shifter operand is an immediate
- shiftOperandIn  in  12  shifter operand field
- imm24In  in  24  signed branch offset, in words
- destIn  in  4  destination register
- freeze  in  1  hold EX/MEM register and status
- flush  in  1  bubble into EX/MEM
- branchTaken  out  1  equals branchIn (combinational)
- branchAddr  out  32  branch target (combinational)
- statusOut  out  4  registered {N,Z,C,V}
- aluResOut  out  32  registered
- valRmOut  out  32  registered store data (effective Rm)
- destOut  out  4  registered
- memReadOut, memWriteOut, wbEnOut  out  1 each  registered

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs and statusOut clear to 0.
- Val2 generation, in priority order:
  - immIn=1: zero-extend shiftOperandIn[7:0], then rotate right by 2*shiftOperandIn[11:8].
  - Else if memReadIn|memWriteIn: zero-extend shiftOperandIn[11:0].
  - Else: Rm shifted by shiftOperandIn[11:7] with type shiftOperandIn[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - A shift amount of 0 passes Rm unchanged for all types.
- ALU commands:
  - 0001 MOV = Val2; 1001 MVN = ~Val2.
  - 0010 ADD = Rn+Val2; 0011 ADC = Rn+Val2+C.
  - 0100 SUB = Rn-Val2; 0101 SBC = Rn-Val2-!C.
  - 0110 AND; 0111 ORR; 1000 EOR.
  - All other codes produce 0 and leave flags unchanged.
  - LDR/STR arrive as ADD; CMP as SUB; TST as AND.
- Flags:
  - N = res[31]; Z = (res==0).
  - Add ops: C = carry-out of the 33-bit sum. Sub ops: C = NOT borrow.
  - V = signed overflow for add/sub.
  - Logic ops and MOV/MVN keep the previous C and V.
- Status register:
  - Loads on a rising edge when sIn=1, freeze=0 and flush=0; otherwise it holds.
  - ADC/SBC read the C value held before the edge.
- EX/MEM register update on each rising edge, in priority order:
  - flush=1: memReadOut, memWriteOut and wbEnOut go to 0; data fields load normally.
  - Else freeze=1: everything holds.
  - Else: all fields load.
  - Latency from ID/EX output to EX/MEM output is 1 cycle.
- Branch: branchAddr = pcIn + (sign-extended imm24In << 2), modulo 2^32. Latency 0.
- The ALU computes every cycle; branch and status logic do not depend on wbEnIn.
- Reset asserted mid-stream clears state immediately. The first edge after release loads the current inputs.

Optional Feature:
- Macro: EXE_FORWARDING_EN.
- When defined, four extra input ports exist:
  - selSrc1 [1:0] and selSrc2 [1:0]
  - memFwdVal [31:0] and wbFwdVal [31:0]
- Operand select for Rn (selSrc1) and Rm (selSrc2): 00 = ID/EX value, 01 = memFwdVal, 10 = wbFwdVal, 11 = ID/EX value.
- The forwarded Rm feeds both the shifter and valRmOut.
- When not defined, these ports are absent and the operands come straight from regRnIn/regRmIn.

Decomposition:
- Package exe_pkg holds:
  - ALU command constants
  - shift-type constants
  - flag bit indices (N=3, Z=2, C=1, V=0)
  - forwarding select constants
- Sub-module exe_alu: combinational ALU plus flag generation (inputs Rn, Val2, cmd, Cin). exe_stage instantiates it.
- Val2 generation and the registers stay in exe_stage.

Test Plan:
- Reset: drive rst=0 with nonzero inputs -> all outputs and statusOut read 0 immediately, no clock needed.
- ADD overflow: Rn=0x7FFFFFFF, immIn=1, shiftOperandIn=0x001, cmd=0010, sIn=1 -> next edge aluResOut=0x80000000, statusOut=1001 (N,V).
- Rotate immediate: immIn=1, shiftOperandIn=0x4FF, cmd=0001 -> aluResOut=0xFF000000.
- Register shift:
  - Rm=0x80000000, shiftOperandIn=0x0C0 (ASR #1), cmd=0001 -> aluResOut=0xC0000000.
  - Same setup with type LSR -> 0x40000000.
- CMP then ADC:
  - Rn=5, Rm=5, cmd=0100, sIn=1, wbEnIn=0 -> statusOut=0110, wbEnOut=0.
  - Next: cmd=0011, Rn=1, Rm=1 -> aluResOut=3.
- Freeze, flush, branch:
  - freeze=1 -> outputs hold across 3 edges.
  - flush=1 with memWriteIn=1, sIn=1 -> memWriteOut=0, status unchanged.
  - pcIn=0x100, imm24In=0xFFFFFE -> branchAddr=0x000000F8 in the same cycle.
